alu_mul_sequencer: RTL

- Multi-cycle sequencer that implements LEGv8 MUL (low WORD bits of the product) by driving the shared execute-stage ALU with shift-add steps.
- Sits beside the ALU in the execute stage. While busy it owns the ALU operand and control inputs through the alu_active mux select.
- It stalls the datapath through busy.
- Operand shifting and bookkeeping are internal; every addition goes through the ALU.

---
 rtl/alu_mul_sequencer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/alu_mul_sequencer.sv
// Shift-add MUL sequencer for the LEGv8 execute stage; borrows the shared ALU
// for every partial-product addition while it stalls the datapath.
module alu_mul_sequencer #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] multiplicand,
   input  logic [WIDTH-1:0] multiplier,
   input  logic [WIDTH-1:0] alu_result,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [3:0]       alu_control,
   output logic             alu_active,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product,
   output logic [CNT_W-1:0] steps
);

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b0010;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0] mplier_r;
   logic [CNT_W-1:0] count_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] product_r;
   logic [CNT_W-1:0] steps_r;

   // Sequencer FSM: operand latch, shift-add stepping, result capture
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r   <= IDLE;
         acc_r     <= '0;
         mcand_r   <= '0;
         mplier_r  <= '0;
         count_r   <= '0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         product_r <= '0;
         steps_r   <= '0;
      end else if (flush) begin
         state_r <= IDLE;
         acc_r   <= '0;
         count_r <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE, DONE: begin
               if (start) begin
                  mcand_r  <= multiplicand;
                  mplier_r <= multiplier;
                  acc_r    <= '0;
                  count_r  <= '0;
                  state_r  <= RUN;
                  busy_r   <= 1'b1;
                  done_r   <= 1'b0;
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b0;
               end
            end
            RUN: begin
               // An empty multiplier means all remaining partial products are zero
               if (mplier_r != '0) begin
                  acc_r    <= alu_result;
                  mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
                  mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
                  count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  product_r <= acc_r;
                  steps_r   <= count_r;
                  state_r   <= DONE;
                  busy_r    <= 1'b0;
                  done_r    <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   // ALU operand drive: add the current partial product while running, idle AND otherwise
   always_comb begin
      alu_a       = '0;
      alu_b       = '0;
      alu_control = ALU_AND;
      if (state_r == RUN) begin
         alu_a       = acc_r;
         alu_b       = mplier_r[0] ? mcand_r : '0;
         alu_control = ALU_ADD;
      end else begin
         alu_a       = '0;
         alu_b       = '0;
         alu_control = ALU_AND;
      end
   end

   assign busy       = busy_r;
   assign alu_active = busy_r;
   assign done       = done_r;
   assign product    = product_r;
   assign steps      = steps_r;

endmodule
